// File: rtl/trailing_zeroes_pkg.sv
// Shared constants and helpers for the trailing-zero counter.
// The count width leaves room for the value DATA_WIDTH itself (all-zero input).
package trailing_zeroes_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    function automatic int count_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/tz_count_comb.sv
// Combinational trailing-zero count: index of the lowest set bit, or DATA_WIDTH if none.
module tz_count_comb
    import trailing_zeroes_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]              din,
    output logic [count_width(DATA_WIDTH)-1:0] count
);

    localparam int CW = count_width(DATA_WIDTH);

    // Scan downward so the least-significant set bit is the last, and winning, assignment.
    always_comb begin
        count = CW'(DATA_WIDTH);
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (din[i]) begin
                count = CW'(i);
            end
        end
    end

endmodule

// File: rtl/trailing_zeroes.sv
// Registered trailing-zero counter with one cycle of latency.
// Results hold while no new word is captured; dout_valid marks the cycle after a capture.
module trailing_zeroes
    import trailing_zeroes_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               din_valid,
    input  logic [DATA_WIDTH-1:0]              din,
    output logic                               dout_valid,
    output logic [count_width(DATA_WIDTH)-1:0] dout
);

    localparam int CW = count_width(DATA_WIDTH);

    logic [CW-1:0] count;

    tz_count_comb #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_count (
        .din  (din),
        .count(count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            dout_valid <= din_valid;
            if (din_valid) begin
                dout <= count;
            end
        end
    end

endmodule

// File: tb/tb_trailing_zeroes.sv
// Self-checking bench for trailing_zeroes at DATA_WIDTH=32 and DATA_WIDTH=8.
module tb_trailing_zeroes;

    logic        clk;
    logic        resetn;
    logic        din_valid;
    logic [31:0] din;
    logic        dout_valid;
    logic [5:0]  dout;

    logic        din_valid8;
    logic [7:0]  din8;
    logic        dout_valid8;
    logic [3:0]  dout8;

    int checks;
    int failures;

    trailing_zeroes #(.DATA_WIDTH(32)) dut32 (
        .clk       (clk),
        .resetn    (resetn),
        .din_valid (din_valid),
        .din       (din),
        .dout_valid(dout_valid),
        .dout      (dout)
    );

    trailing_zeroes #(.DATA_WIDTH(8)) dut8 (
        .clk       (clk),
        .resetn    (resetn),
        .din_valid (din_valid8),
        .din       (din8),
        .dout_valid(dout_valid8),
        .dout      (dout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: isolate the lowest set bit arithmetically and take its log2.
    function automatic int tz_model(input logic [63:0] x, input int w);
        logic [63:0] lowest;
        if (x == 64'd0) return w;
        lowest = x & (~x + 64'd1);
        return $clog2(lowest);
    endfunction

    task automatic test_reset();
        resetn    = 1'b0;
        din_valid = 1'b1;
        din       = 32'h0000_0010;
        din_valid8 = 1'b1;
        din8      = 8'h04;
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== 6'd0 || dout_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_32: dout=%0d valid=%b expected 0/0", dout, dout_valid);
        end
        checks++;
        if (dout8 !== 4'd0 || dout_valid8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_8: dout=%0d valid=%b expected 0/0", dout8, dout_valid8);
        end
        din_valid  = 1'b0;
        din_valid8 = 1'b0;
        resetn     = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed32();
        logic [31:0] words [5];
        int exp;
        words[0] = 32'h0000_0008;
        words[1] = 32'h0000_0000;
        words[2] = 32'h8000_0000;
        words[3] = 32'h0000_0001;
        words[4] = 32'hA5A5_0400;
        for (int i = 0; i < 5; i++) begin
            din       = words[i];
            din_valid = 1'b1;
            @(negedge clk);
            din_valid = 1'b0;
            exp = tz_model({32'd0, words[i]}, 32);
            checks++;
            if (dout !== 6'(exp) || dout_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL directed32_%h: dout=%0d valid=%b expected %0d/1",
                         words[i], dout, dout_valid, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int moduli [4];
        int exp_q [$];
        logic [31:0] w;
        int exp;
        moduli[0] = 16;
        moduli[1] = 32;
        moduli[2] = 64;
        moduli[3] = 128;
        for (int m = 0; m < 4; m++) begin
            for (int k = 0; k < 5; k++) begin
                w = $urandom % moduli[m];
                din       = w;
                din_valid = 1'b1;
                exp_q.push_back(tz_model({32'd0, w}, 32));
                @(negedge clk);
                exp = exp_q.pop_front();
                checks++;
                if (dout !== 6'(exp) || dout_valid !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL b2b_mod%0d_%0d: din=%h dout=%0d valid=%b expected %0d/1",
                             moduli[m], k, w, dout, dout_valid, exp);
                end
            end
        end
        din_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold();
        din       = 32'hFFFF_FFF0;
        din_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (dout !== 6'd4 || dout_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_first: dout=%0d valid=%b expected 4/1", dout, dout_valid);
        end
        din_valid = 1'b0;
        din       = 'x;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dout !== 6'd4 || dout_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_idle%0d: dout=%0d valid=%b expected 4/0", i, dout, dout_valid);
            end
        end
        din = 32'd0;
    endtask

    task automatic test_reset_midstream();
        din       = 32'h0000_0100;
        din_valid = 1'b1;
        @(negedge clk);
        din = 32'h0000_0200;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (dout !== 6'd0 || dout_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_async: dout=%0d valid=%b expected 0/0", dout, dout_valid);
        end
        @(negedge clk);
        checks++;
        if (dout !== 6'd0 || dout_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_held: dout=%0d valid=%b expected 0/0", dout, dout_valid);
        end
        resetn = 1'b1;
        din    = 32'h0000_0020;
        @(negedge clk);
        din_valid = 1'b0;
        checks++;
        if (dout !== 6'd5 || dout_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release: dout=%0d valid=%b expected 5/1", dout, dout_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_width8();
        logic [7:0] words [6];
        int exp;
        words[0] = 8'h08;
        words[1] = 8'h00;
        words[2] = 8'h80;
        words[3] = 8'h01;
        words[4] = 8'h40;
        words[5] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            din8       = words[i];
            din_valid8 = 1'b1;
            @(negedge clk);
            din_valid8 = 1'b0;
            exp = tz_model({56'd0, words[i]}, 8);
            checks++;
            if (dout8 !== 4'(exp) || dout_valid8 !== 1'b1) begin
                failures++;
                $display("[TB] FAIL width8_%h: dout=%0d valid=%b expected %0d/1",
                         words[i], dout8, dout_valid8, exp);
            end
            @(negedge clk);
            checks++;
            if (dout8 !== 4'(exp) || dout_valid8 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL width8_idle_%h: dout=%0d valid=%b expected %0d/0",
                         words[i], dout8, dout_valid8, exp);
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        din        = '0;
        din_valid  = 1'b0;
        din8       = '0;
        din_valid8 = 1'b0;
        resetn     = 1'b0;
        test_reset();
        test_directed32();
        test_back_to_back();
        test_hold();
        test_reset_midstream();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/trailing_zeroes.md
TRAILING_ZEROES -- requirements
Module: trailing_zeroes

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the input word; SHALL support any value from 1 to 1024.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 din_valid  input  1  qualifies din for capture in the current cycle.
REQ-005 din  input  DATA_WIDTH  word whose trailing (LSB-side) zero bits are counted.
REQ-006 dout_valid  output  1  asserted when dout holds the result for a captured word.
REQ-007 dout  output  $clog2(DATA_WIDTH)+1  count of consecutive zero bits starting at din[0].

Function
REQ-008 dout SHALL equal the index of the least-significant 1 bit of the captured din.
REQ-009 If the captured din is all zeros, dout SHALL equal DATA_WIDTH (32 at default).
REQ-010 dout width SHALL be $clog2(DATA_WIDTH)+1 bits, so the value DATA_WIDTH is representable without wrap.
REQ-011 Latency SHALL be exactly one clock: din sampled with din_valid=1 at edge N appears on dout with dout_valid=1 after edge N.
REQ-012 dout_valid SHALL follow din_valid delayed by one cycle; back-to-back valid inputs SHALL give back-to-back results, one per cycle, with no stalls.
REQ-013 When din_valid=0 at an edge, dout SHALL hold its previous value and dout_valid SHALL deassert.
REQ-014 din bits above the least-significant 1 SHALL NOT affect dout.
REQ-015 The counting logic SHALL be combinational between the input capture and the output register, with no extra pipeline stage.
REQ-016 din containing X/Z while din_valid=0 SHALL NOT change dout or dout_valid.

Reset
REQ-017 While resetn=0, dout SHALL be 0 and dout_valid SHALL be 0, immediately and independent of clk.
REQ-018 Reset asserted mid-stream SHALL discard any in-flight result; the first valid output after release SHALL come from a word captured after release.
REQ-019 Deassertion of resetn SHALL be treated as synchronous to clk; the first capture SHALL occur on the first rising edge with resetn=1.

Structure
REQ-020 A shared package trailing_zeroes_pkg SHALL hold DEFAULT_DATA_WIDTH=32 and a function or localparam that derives the count width, $clog2(w)+1.
REQ-021 One sub-module, tz_count_comb (parameter DATA_WIDTH; din in, count out), SHALL implement the combinational count as a parameterised priority scan from LSB to MSB, or as an equivalent tree.
REQ-022 The top level SHALL contain only the valid/result registers and the instance of tz_count_comb.

Verification
REQ-023 din=32'h0000_0008 with din_valid=1 -> next cycle dout=3, dout_valid=1.
REQ-024 din=32'h0000_0000 -> dout=32; din=32'h8000_0000 -> dout=31; din=32'h0000_0001 -> dout=0.
REQ-025 Random din taken modulo 16, 32, 64 and 128, five words each, back-to-back -> each dout matches a reference model one cycle later, and dout_valid stays 1 throughout.
REQ-026 din=32'hFFFF_FFF0 followed by din_valid=0 for 3 cycles -> dout=4 held, with dout_valid 1 then 0.
REQ-027 resetn pulsed low between clock edges during a stream -> dout=0 and dout_valid=0 immediately, and the next result comes from a post-release input.
REQ-028 Repeat REQ-023 and REQ-024 with DATA_WIDTH=8: din=8'h00 -> dout=8 (4-bit output), din=8'h40 -> dout=6.
